vga_fill_ctrl: RTL and testbench

Write-port controller for the VGA color framebuffer: shares the buffer's single write port between CPU stores and a hardware rectangle-fill engine. Sits between the CPU memory stage and the color framebuffer. Lets software clear or paint a rectangle with one command instead of thousands of stores. CPU stores always win the port; the fill engine uses idle cycles and emits byte or aligned-word writes.

---
 rtl/vga_fill_ctrl_if.sv | 42 ++++
 rtl/vga_fill_ctrl.sv | 129 ++++++++++++
 tb/tb_vga_fill_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fill_ctrl_if.sv
// Framebuffer write-port bundle: CPU store path, fill command channel and the
// single arbitrated write port toward the color framebuffer.
interface vga_fill_ctrl_if;
  logic        i_cpuWrite;
  logic [31:0] i_cpuAddr;
  logic [31:0] i_cpuData;
  logic [1:0]  i_cpuSize;

  // Command channel is valid/ready: a command transfers on a rising edge where
  // i_cmdValid and o_cmdReady are both high; the source must hold every
  // i_cmd* field stable and keep i_cmdValid high until that edge.
  logic        i_cmdValid;
  logic        o_cmdReady;
  logic [6:0]  i_cmdX0;
  logic [6:0]  i_cmdY0;
  logic [7:0]  i_cmdW;
  logic [7:0]  i_cmdH;
  logic [3:0]  i_cmdColor;
  logic        i_abort;

  logic        o_memWrite;
  logic [31:0] o_pxlAddr;
  logic [31:0] o_pxlData;
  logic [1:0]  o_size;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_state;

  modport slave (
    input  i_cpuWrite, i_cpuAddr, i_cpuData, i_cpuSize,
    input  i_cmdValid, i_cmdX0, i_cmdY0, i_cmdW, i_cmdH, i_cmdColor, i_abort,
    output o_cmdReady, o_memWrite, o_pxlAddr, o_pxlData, o_size,
    output o_busy, o_done, o_state
  );

  modport master (
    output i_cpuWrite, i_cpuAddr, i_cpuData, i_cpuSize,
    output i_cmdValid, i_cmdX0, i_cmdY0, i_cmdW, i_cmdH, i_cmdColor, i_abort,
    input  o_cmdReady, o_memWrite, o_pxlAddr, o_pxlData, o_size,
    input  o_busy, o_done, o_state
  );
endinterface

// File: rtl/vga_fill_ctrl.sv
// Shares the framebuffer write port between CPU stores (always granted) and a
// rectangle-fill engine that uses idle cycles for byte / aligned-word writes.
module vga_fill_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 120
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  vga_fill_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [8:0] COLS9 = 9'(COLS);
  localparam logic [8:0] ROWS9 = 9'(ROWS);

  state_e     state_q, state_d;
  logic [6:0] x0_q, x0_d;
  logic [6:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic [7:0] xend_q, xend_d;
  logic [7:0] yend_q, yend_d;
  logic [3:0] color_q, color_d;

  logic [8:0] x_sum, y_sum;
  logic [7:0] x_clip, y_clip;
  logic       degenerate;
  logic       eng_wr;
  logic       use_word;
  logic       row_last;
  logic [7:0] col_ext, span, col_next;

  // Clip bounds in 9 bits so X0+W / Y0+H can never wrap before the min().
  assign x_sum      = {2'b00, bus.i_cmdX0} + {1'b0, bus.i_cmdW};
  assign y_sum      = {2'b00, bus.i_cmdY0} + {1'b0, bus.i_cmdH};
  assign x_clip     = (x_sum > COLS9) ? COLS9[7:0] : x_sum[7:0];
  assign y_clip     = (y_sum > ROWS9) ? ROWS9[7:0] : y_sum[7:0];
  assign degenerate = (bus.i_cmdW == 8'd0) || (bus.i_cmdH == 8'd0) ||
                      ({2'b00, bus.i_cmdX0} >= COLS9) ||
                      ({2'b00, bus.i_cmdY0} >= ROWS9);

  assign eng_wr   = (state_q == S_FILL) && !bus.i_cpuWrite;
  assign col_ext  = {1'b0, col_q};
  assign span     = xend_q - col_ext;
  assign use_word = (col_q[1:0] == 2'b00) && (span >= 8'd4);
  assign col_next = col_ext + (use_word ? 8'd4 : 8'd1);
  assign row_last = (({1'b0, row_q} + 8'd1) == yend_q);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      xend_q  <= '0;
      yend_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xend_q  <= xend_d;
      yend_q  <= yend_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    col_d   = col_q;
    row_d   = row_q;
    xend_d  = xend_q;
    yend_d  = yend_q;
    color_d = color_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_cmdValid) begin
          x0_d    = bus.i_cmdX0;
          col_d   = bus.i_cmdX0;
          row_d   = bus.i_cmdY0;
          xend_d  = x_clip;
          yend_d  = y_clip;
          color_d = bus.i_cmdColor;
          state_d = degenerate ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        // Cursor only advances on cycles the engine actually owns the port.
        if (eng_wr) begin
          if (col_next == xend_q) begin
            col_d = x0_q;
            row_d = row_q + 7'd1;
            if (row_last) state_d = S_DONE;
          end else begin
            col_d = col_next[6:0];
          end
        end
        if (bus.i_abort) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_memWrite = bus.i_cpuWrite;
    bus.o_pxlAddr  = bus.i_cpuAddr;
    bus.o_pxlData  = bus.i_cpuData;
    bus.o_size     = bus.i_cpuSize;
    if (eng_wr) begin
      bus.o_memWrite = 1'b1;
      bus.o_pxlAddr  = {17'd0, row_q, 1'b0, col_q};
      bus.o_pxlData  = {8{color_q}};
      bus.o_size     = use_word ? 2'b10 : 2'b00;
    end
  end

  assign bus.o_cmdReady = (state_q == S_IDLE);
  assign bus.o_busy     = (state_q == S_FILL);
  assign bus.o_done     = (state_q == S_DONE);
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Bench for vga_fill_ctrl: command vector table, an independent write model
// feeding an expected queue, and hand sequences for contention/abort/reset.
module tb_vga_fill_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   eng_cnt = 0;
  int   cpu_cnt = 0;
  int   done_cnt = 0;

  logic [65:0] exp_q[$];

  vga_fill_ctrl_if bus();

  vga_fill_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic int push_exp(input int x0, input int y0, input int w, input int h,
                                  input logic [3:0] color, input int maxn);
    int n, xe, ye, c, st;
    logic [1:0] sz;
    logic [31:0] a, d;
    n = 0;
    if (w == 0 || h == 0 || x0 >= COLS || y0 >= ROWS) return 0;
    xe = (x0 + w > COLS) ? COLS : x0 + w;
    ye = (y0 + h > ROWS) ? ROWS : y0 + h;
    d = {8{color}};
    for (int r = y0; r < ye; r++) begin
      c = x0;
      while (c < xe) begin
        if ((c % 4) == 0 && (xe - c) >= 4) begin sz = 2'b10; st = 4; end
        else begin sz = 2'b00; st = 1; end
        a = 32'((r << 8) | c);
        exp_q.push_back({a, d, sz});
        n++;
        if (n == maxn) return n;
        c += st;
      end
    end
    return n;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_done) done_cnt++;
      if (bus.o_memWrite) begin
        if (bus.i_cpuWrite) begin
          cpu_cnt++;
          check("cpu_pass", {bus.o_pxlAddr, bus.o_pxlData, bus.o_size},
                            {bus.i_cpuAddr, bus.i_cpuData, bus.i_cpuSize});
        end else begin
          eng_cnt++;
          check("busy_in_fill", bus.o_busy, 1'b1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_eng_wr actual=%0h expected=none", bus.o_pxlAddr);
          end else begin
            check("eng_wr", {bus.o_pxlAddr, bus.o_pxlData, bus.o_size}, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int x0, input int y0, input int w, input int h,
                          input logic [3:0] color, output int acc);
    bit got;
    got = 0;
    @(posedge clk); #1;
    bus.i_cmdX0 = 7'(x0);
    bus.i_cmdY0 = 7'(y0);
    bus.i_cmdW = 8'(w);
    bus.i_cmdH = 8'(h);
    bus.i_cmdColor = color;
    bus.i_cmdValid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.o_cmdReady) begin got = 1; break; end
    end
    check("cmd_ready_seen", got, 1'b1);
    @(posedge clk); #1;
    bus.i_cmdValid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(output int dcyc);
    bit ok;
    ok = 0;
    dcyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.o_done) begin ok = 1; dcyc = cyc; break; end
    end
    check("done_seen", ok, 1'b1);
    if (ok) begin
      check("done_not_ready", bus.o_cmdReady, 1'b0);
      check("done_not_busy", bus.o_busy, 1'b0);
      @(negedge clk);
      check("ready_after_done", bus.o_cmdReady, 1'b1);
    end else begin
      exp_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int x0; int y0; int w; int h; logic [3:0] color; int exp_writes;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int acc, dcyc, e0, c0, d0, n;
    vecs[0]  = '{0,   0,   8,   2,   4'hA, 4};
    vecs[1]  = '{3,   5,   6,   1,   4'h5, 3};
    vecs[2]  = '{78,  119, 10,  5,   4'h3, 2};
    vecs[3]  = '{10,  10,  0,   3,   4'h1, 0};
    vecs[4]  = '{80,  0,   4,   1,   4'h2, 0};
    vecs[5]  = '{0,   120, 4,   1,   4'h2, 0};
    vecs[6]  = '{5,   5,   4,   0,   4'h2, 0};
    vecs[7]  = '{1,   2,   3,   2,   4'hC, 6};
    vecs[8]  = '{0,   0,   80,  1,   4'hF, 20};
    vecs[9]  = '{126, 3,   9,   2,   4'h4, 0};
    vecs[10] = '{2,   117, 200, 200, 4'h9, 63};

    bus.i_cpuWrite = 0; bus.i_cpuAddr = 0; bus.i_cpuData = 0; bus.i_cpuSize = 0;
    bus.i_cmdValid = 0; bus.i_cmdX0 = 0; bus.i_cmdY0 = 0; bus.i_cmdW = 0;
    bus.i_cmdH = 0; bus.i_cmdColor = 0; bus.i_abort = 0;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.o_cmdReady, 1'b1);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
    check("rst_memwrite", bus.o_memWrite, 1'b0);
    check("rst_state", bus.o_state, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // CPU pass-through while idle
    bus.i_cpuWrite = 1; bus.i_cpuAddr = 32'h40; bus.i_cpuData = 32'h12345678; bus.i_cpuSize = 2'b00;
    @(negedge clk);
    check("idle_cpu_we", bus.o_memWrite, 1'b1);
    @(posedge clk); #1;
    bus.i_cpuWrite = 0;

    // table-driven commands
    for (int i = 0; i < 11; i++) begin
      void'(push_exp(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, 1000));
      e0 = eng_cnt;
      send_cmd(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, acc);
      wait_done(dcyc);
      check($sformatf("v%0d_latency", i), 80'(dcyc - acc), 80'(vecs[i].exp_writes));
      check($sformatf("v%0d_writes", i), 80'(eng_cnt - e0), 80'(vecs[i].exp_writes));
      check($sformatf("v%0d_drained", i), 80'(exp_q.size()), 80'd0);
    end

    // random commands against the model
    for (int i = 0; i < 4; i++) begin
      int rx, ry, rw, rh;
      rx = $urandom_range(0, 85);
      ry = $urandom_range(0, 125);
      rw = $urandom_range(0, 40);
      rh = $urandom_range(0, 4);
      n = push_exp(rx, ry, rw, rh, 4'($urandom_range(0, 15)), 1000);
      e0 = eng_cnt;
      send_cmd(rx, ry, rw, rh, exp_q.size() > 0 ? exp_q[$][5:2] : 4'h0, acc);
      wait_done(dcyc);
      check($sformatf("r%0d_latency", i), 80'(dcyc - acc), 80'(n));
      check($sformatf("r%0d_writes", i), 80'(eng_cnt - e0), 80'(n));
    end

    // CPU contention during an aligned fill
    void'(push_exp(0, 0, 8, 2, 4'hA, 1000));
    e0 = eng_cnt; c0 = cpu_cnt;
    send_cmd(0, 0, 8, 2, 4'hA, acc);
    @(posedge clk); #1;
    bus.i_cpuWrite = 1; bus.i_cpuAddr = 32'h1234; bus.i_cpuData = 32'hDEADBEEF; bus.i_cpuSize = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    bus.i_cpuWrite = 0;
    wait_done(dcyc);
    check("cont_latency", 80'(dcyc - acc), 80'd7);
    check("cont_eng_writes", 80'(eng_cnt - e0), 80'd4);
    check("cont_cpu_writes", 80'(cpu_cnt - c0), 80'd3);

    // abort on the second engine write of a 4-row fill
    void'(push_exp(0, 10, 4, 4, 4'h7, 2));
    e0 = eng_cnt;
    send_cmd(0, 10, 4, 4, 4'h7, acc);
    @(posedge clk); #1;
    bus.i_abort = 1;
    @(posedge clk); #1;
    bus.i_abort = 0;
    wait_done(dcyc);
    check("abort_latency", 80'(dcyc - acc), 80'd2);
    repeat (5) @(negedge clk);
    check("abort_writes", 80'(eng_cnt - e0), 80'd2);
    check("abort_drained", 80'(exp_q.size()), 80'd0);

    // synchronous reset during the second engine write
    void'(push_exp(0, 10, 4, 4, 4'h7, 1));
    e0 = eng_cnt; d0 = done_cnt;
    send_cmd(0, 10, 4, 4, 4'h7, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready", bus.o_cmdReady, 1'b1);
    check("mrst_busy", bus.o_busy, 1'b0);
    check("mrst_state", bus.o_state, 2'd0);
    repeat (6) @(negedge clk);
    check("mrst_writes", 80'(eng_cnt - e0), 80'd1);
    check("mrst_no_done", 80'(done_cnt - d0), 80'd0);
    check("mrst_drained", 80'(exp_q.size()), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
